// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory latency responder.
//  - state_e : two-state access FSM encoding
//  - LAT_W / BE_W / DWIDTH : latency, byte-enable and data widths
//  - eff_latency() : maps a requested latency of 0 onto 1
package dmem_pkg;

    localparam int LAT_W  = 3;
    localparam int BE_W   = 4;
    localparam int DWIDTH = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // A latency of zero behaves exactly like a single-cycle access.
    function automatic logic [LAT_W-1:0] eff_latency(input logic [LAT_W-1:0] lat);
        logic [LAT_W-1:0] res;
        if (lat == {LAT_W{1'b0}}) begin
            res = {{(LAT_W-1){1'b0}}, 1'b1};
        end else begin
            res = lat;
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Single-port synchronous word array with per-byte write enables.
//  i_clk   : clock
//  i_en    : perform an access on this edge
//  i_we    : 1 = write enabled bytes, 0 = read whole word into o_rdata
//  i_addr  : word address (caller guarantees it is below SIZE when i_en=1)
//  i_be    : byte enables for writes
//  i_wdata : write data
//  o_rdata : registered read data, only updated by reads
// The array contents are never reset.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int AWIDTH    = 12,
    parameter int SIZE      = 4096,
    parameter     INIT_FILE = ""
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [BE_W-1:0]   i_be,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [SIZE];
    logic [DWIDTH-1:0] r_rdata;

    // Array access: byte-masked write or full-word registered read.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_latency_responder.sv
// Data-memory responder with run-time selectable access latency.
//  CLK, RSTn        : clock, asynchronous active-low reset
//  CSN, WEN         : request select (active low), 0 = write / 1 = read
//  ADDR, BE, DI     : word address, byte enables, write data
//  LATENCY          : access latency in cycles (0 behaves as 1)
//  DOUT             : data of the last completed read (0 for out-of-range reads)
//  READY            : 0 while an accepted access is still waiting
//  STALL_CNT        : saturating count of cycles spent with READY low
// Requests are latched at acceptance; the access itself (write commit or read)
// happens on the edge where the latency count expires, or on the accepting
// edge for single-cycle accesses.
module dmem_latency_responder
    import dmem_pkg::*;
#(
    parameter int AWIDTH    = 12,
    parameter int SIZE      = 4096,
    parameter     INIT_FILE = ""
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CSN,
    input  logic              WEN,
    input  logic [AWIDTH-1:0] ADDR,
    input  logic [BE_W-1:0]   BE,
    input  logic [DWIDTH-1:0] DI,
    input  logic [LAT_W-1:0]  LATENCY,
    output logic [DWIDTH-1:0] DOUT,
    output logic              READY,
    output logic [31:0]       STALL_CNT
);

    localparam logic [AWIDTH:0] SIZE_LIM = (AWIDTH+1)'(SIZE);

    state_e            r_state;
    logic [LAT_W-1:0]  r_cnt;
    logic              r_wen;
    logic [AWIDTH-1:0] r_addr;
    logic [BE_W-1:0]   r_be;
    logic [DWIDTH-1:0] r_di;
    logic              r_ready;
    logic [31:0]       r_stall_cnt;
    logic              r_dout_zero;

    state_e            w_state_nxt;
    logic [LAT_W-1:0]  w_cnt_nxt;
    logic              w_ready_nxt;
    logic              w_latch;
    logic              w_acc_en;
    logic              w_acc_we;
    logic [AWIDTH-1:0] w_acc_addr;
    logic [BE_W-1:0]   w_acc_be;
    logic [DWIDTH-1:0] w_acc_di;
    logic [LAT_W-1:0]  w_lat;
    logic              w_in_range;
    logic              w_mem_en;
    logic [DWIDTH-1:0] w_rdata;

    assign w_lat = eff_latency(LATENCY);

    // Next-state, latch control and access selection for the two-state FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = r_ready;
        w_latch     = 1'b0;
        w_acc_en    = 1'b0;
        w_acc_we    = ~r_wen;
        w_acc_addr  = r_addr;
        w_acc_be    = r_be;
        w_acc_di    = r_di;
        case (r_state)
            ST_IDLE: begin
                if (!CSN) begin
                    if (w_lat == 3'd1) begin
                        // Single-cycle access uses the live request directly.
                        w_acc_en    = 1'b1;
                        w_acc_we    = ~WEN;
                        w_acc_addr  = ADDR;
                        w_acc_be    = BE;
                        w_acc_di    = DI;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = w_lat - 3'd1;
                        w_ready_nxt = 1'b0;
                    end
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_acc_en    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    assign w_in_range = ({1'b0, w_acc_addr} < SIZE_LIM);
    // Out-of-range accesses never touch the array; RSTn gating keeps a
    // request presented during reset from committing.
    assign w_mem_en   = w_acc_en & w_in_range & RSTn;

    // FSM state, latency counter and READY.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Request latches captured on a multi-cycle acceptance.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wen  <= 1'b1;
            r_addr <= {AWIDTH{1'b0}};
            r_be   <= 4'b0000;
            r_di   <= 32'h0000_0000;
        end else if (w_latch) begin
            r_wen  <= WEN;
            r_addr <= ADDR;
            r_be   <= BE;
            r_di   <= DI;
        end
    end

    // DOUT zero-mask: set by reset and by out-of-range reads, cleared by
    // in-range reads, so DOUT holds across writes and idle cycles.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_dout_zero <= 1'b1;
        end else if (w_acc_en && !w_acc_we) begin
            r_dout_zero <= ~w_in_range;
        end
    end

    // Saturating count of cycles that began with READY low.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_stall_cnt <= 32'h0000_0000;
        end else if (!r_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    dmem_byte_array #(
        .AWIDTH    (AWIDTH),
        .SIZE      (SIZE),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .i_clk   (CLK),
        .i_en    (w_mem_en),
        .i_we    (w_acc_we),
        .i_addr  (w_acc_addr),
        .i_be    (w_acc_be),
        .i_wdata (w_acc_di),
        .o_rdata (w_rdata)
    );

    assign DOUT      = r_dout_zero ? 32'h0000_0000 : w_rdata;
    assign READY     = r_ready;
    assign STALL_CNT = r_stall_cnt;

endmodule

// File: tb/tb_dmem_latency_responder.sv
// Directed bench for dmem_latency_responder (AWIDTH=5, SIZE=16 so that
// out-of-range addresses are reachable).
module tb_dmem_latency_responder;

    logic        CLK;
    logic        RSTn;
    logic        CSN;
    logic        WEN;
    logic [4:0]  ADDR;
    logic [3:0]  BE;
    logic [31:0] DI;
    logic [2:0]  LATENCY;
    logic [31:0] DOUT;
    logic        READY;
    logic [31:0] STALL_CNT;

    int n_cmp;
    int n_bad;
    int stall_exp;

    dmem_latency_responder #(
        .AWIDTH    (5),
        .SIZE      (16),
        .INIT_FILE ("")
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .CSN       (CSN),
        .WEN       (WEN),
        .ADDR      (ADDR),
        .BE        (BE),
        .DI        (DI),
        .LATENCY   (LATENCY),
        .DOUT      (DOUT),
        .READY     (READY),
        .STALL_CNT (STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one request just after an edge, then wait (bounded) for READY.
    task automatic access(input logic wen, input logic [4:0] addr, input logic [3:0] be,
                          input logic [31:0] di, input logic [2:0] lat, output int stalls);
        CSN = 1'b0; WEN = wen; ADDR = addr; BE = be; DI = di; LATENCY = lat;
        @(posedge CLK); #1;
        CSN = 1'b1; WEN = 1'b1;
        stalls = 0;
        while (READY !== 1'b1 && stalls < 16) begin
            @(posedge CLK); #1;
            stalls++;
        end
    endtask

    task automatic wr(input string tag, input logic [4:0] addr, input logic [3:0] be,
                      input logic [31:0] di, input logic [2:0] lat, input int exp_stalls);
        int s;
        access(1'b0, addr, be, di, lat, s);
        check_val(tag, 32'(s), 32'(exp_stalls));
        stall_exp += exp_stalls;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [2:0] lat,
                      input int exp_stalls, input logic [31:0] exp_data);
        int s;
        access(1'b1, addr, 4'b0000, 32'h0, lat, s);
        check_val({tag, "_stalls"}, 32'(s), 32'(exp_stalls));
        check_val({tag, "_data"}, DOUT, exp_data);
        stall_exp += exp_stalls;
    endtask

    initial begin
        int s;
        n_cmp = 0; n_bad = 0; stall_exp = 0;
        RSTn = 1'b0; CSN = 1'b1; WEN = 1'b1; ADDR = 5'd0; BE = 4'b0000;
        DI = 32'h0; LATENCY = 3'd1;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_ready", {31'd0, READY}, 32'd1);
        check_val("rst_dout", DOUT, 32'h0);
        check_val("rst_stall", STALL_CNT, 32'h0);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // 1: reset in the middle of a multi-cycle write discards it.
        wr("t1_pre", 5'd5, 4'b1111, 32'hAAAA_5555, 3'd1, 0);
        CSN = 1'b0; WEN = 1'b0; ADDR = 5'd5; BE = 4'b1111; DI = 32'h1234_5678; LATENCY = 3'd4;
        @(posedge CLK); #1;
        CSN = 1'b1; WEN = 1'b1;
        check_val("t1_wait_ready", {31'd0, READY}, 32'd0);
        @(posedge CLK); #1;
        RSTn = 1'b0; stall_exp = 0;
        #1;
        check_val("t1_ready", {31'd0, READY}, 32'd1);
        check_val("t1_dout", DOUT, 32'h0);
        check_val("t1_stall", STALL_CNT, 32'h0);
        #2 RSTn = 1'b1;
        @(posedge CLK); #1;
        rd("t1_mem5", 5'd5, 3'd1, 0, 32'hAAAA_5555);

        // 2: back-to-back single-cycle write then read.
        CSN = 1'b0; WEN = 1'b0; ADDR = 5'd3; BE = 4'b1111; DI = 32'hDEAD_BEEF; LATENCY = 3'd1;
        @(posedge CLK); #1;
        check_val("t2_wr_ready", {31'd0, READY}, 32'd1);
        WEN = 1'b1;
        @(posedge CLK); #1;
        CSN = 1'b1;
        check_val("t2_rd_ready", {31'd0, READY}, 32'd1);
        check_val("t2_rd_data", DOUT, 32'hDEAD_BEEF);

        // 3: latency 4 read stalls exactly 3 cycles.
        rd("t3", 5'd3, 3'd4, 3, 32'hDEAD_BEEF);
        check_val("t3_stallcnt", STALL_CNT, 32'(stall_exp));

        // 4: partial byte write.
        wr("t4_clr", 5'd7, 4'b1111, 32'h0, 3'd1, 0);
        wr("t4_be", 5'd7, 4'b0101, 32'h1122_3344, 3'd2, 1);
        rd("t4", 5'd7, 3'd1, 0, 32'h0022_0044);
        wr("t4_be0", 5'd7, 4'b0000, 32'hFFFF_FFFF, 3'd3, 2);
        rd("t4_noop", 5'd7, 3'd0, 0, 32'h0022_0044);

        // 5: inputs changed during WAIT are ignored.
        wr("t5_pre", 5'd9, 4'b1111, 32'h9999_9999, 3'd1, 0);
        rd("t5_pre", 5'd9, 3'd1, 0, 32'h9999_9999);
        CSN = 1'b0; WEN = 1'b1; ADDR = 5'd3; LATENCY = 3'd3;
        @(posedge CLK); #1;
        CSN = 1'b1; ADDR = 5'd9; LATENCY = 3'd1;
        s = 0;
        while (READY !== 1'b1 && s < 16) begin
            @(posedge CLK); #1;
            s++;
        end
        stall_exp += 2;
        check_val("t5_stalls", 32'(s), 32'd2);
        check_val("t5_data", DOUT, 32'hDEAD_BEEF);

        // 6: out-of-range accesses; word 4 would be hit if the address wrapped.
        wr("t6_pre", 5'd4, 4'b1111, 32'h0000_55AA, 3'd1, 0);
        wr("t6_wr", 5'd20, 4'b1111, 32'hCAFE_F00D, 3'd2, 1);
        rd("t6_rd", 5'd20, 3'd1, 0, 32'h0);
        rd("t6_m4", 5'd4, 3'd1, 0, 32'h0000_55AA);
        rd("t6_m3", 5'd3, 3'd1, 0, 32'hDEAD_BEEF);
        rd("t6_m7", 5'd7, 3'd2, 1, 32'h0022_0044);
        rd("t6_rd_lat", 5'd20, 3'd3, 2, 32'h0);

        check_val("final_stallcnt", STALL_CNT, 32'(stall_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
